// File: rtl/star_bbox_finder_if.sv
// Request/result handshake and frame-RAM read port of the star bounding-box finder.
// The slave modport is the finder; the master modport is its environment (detector + RAM).
interface star_bbox_finder_if #(
  parameter int X_W    = 3,
  parameter int Y_W    = 3,
  parameter int PIX_W  = 3,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [X_W-1:0]    x_in;
  logic [Y_W-1:0]    y_in;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_q;
  logic              busy;
  logic              done;
  logic              err;
  logic [X_W-1:0]    left;
  logic [X_W-1:0]    right;
  logic [Y_W-1:0]    top;
  logic [Y_W-1:0]    bottom;
  logic [X_W-1:0]    mid_x;
  logic [Y_W-1:0]    mid_y;

  modport master (
    output start, x_in, y_in, mem_q,
    input  mem_addr, busy, done, err, left, right, top, bottom, mid_x, mid_y
  );

  modport slave (
    input  start, x_in, y_in, mem_q,
    output mem_addr, busy, done, err, left, right, top, bottom, mid_x, mid_y
  );
endinterface

// File: rtl/star_bbox_finder.sv
// Walks the frame RAM from a seed pixel and reports the star's bounding box and centre.
// Scan order: right, left (row of the seed), then down, up (column mid_x).
module star_bbox_finder #(
  parameter int X_RES     = 6,
  parameter int Y_RES     = 6,
  parameter int X_W       = 3,
  parameter int Y_W       = 3,
  parameter int PIX_W     = 3,
  parameter int ADDR_W    = 6,
  parameter int THRESHOLD = 0
) (
  input logic                clk,
  input logic                resetn,
  star_bbox_finder_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, SEED_REQ, SEED_CHK, RIGHT_REQ, RIGHT_CHK, LEFT_REQ, LEFT_CHK,
    DOWN_REQ, DOWN_CHK, UP_REQ, UP_CHK, DONE
  } state_t;

  state_t            state;
  logic [Y_W-1:0]    ySeed;
  logic [X_W-1:0]    leftR, rightR, midXR;
  logic [Y_W-1:0]    topR, bottomR, midYR;
  logic              errR, busyR, doneR;
  logic [ADDR_W-1:0] addrR;

  logic              bright;
  logic              seedDark;
  state_t            nextReq;
  logic [X_W-1:0]    nLeft, nRight, nMidX;
  logic [Y_W-1:0]    nTop, nBottom, nMidY;
  logic [X_W:0]      sumX;
  logic [Y_W:0]      sumY;
  logic [ADDR_W-1:0] nextAddr;

  function automatic logic [ADDR_W-1:0] addrOf(input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
    return ADDR_W'(y) * ADDR_W'(X_RES) + ADDR_W'(x);
  endfunction

  // Evaluate the pending probe, then skip every scan already at the frame edge so that
  // the next request goes straight out on the same edge.
  always_comb begin
    bright   = bus.mem_q > PIX_W'(THRESHOLD);
    seedDark = 1'b0;
    nLeft    = leftR;
    nRight   = rightR;
    nTop     = topR;
    nBottom  = bottomR;
    nextReq  = DONE;
    case (state)
      SEED_CHK:  if (bright) nextReq = RIGHT_REQ; else seedDark = 1'b1;
      RIGHT_CHK: if (bright) begin nRight = rightR + X_W'(1); nextReq = RIGHT_REQ; end
                 else nextReq = LEFT_REQ;
      LEFT_CHK:  if (bright) begin nLeft = leftR - X_W'(1); nextReq = LEFT_REQ; end
                 else nextReq = DOWN_REQ;
      DOWN_CHK:  if (bright) begin nBottom = bottomR + Y_W'(1); nextReq = DOWN_REQ; end
                 else nextReq = UP_REQ;
      UP_CHK:    if (bright) begin nTop = topR - Y_W'(1); nextReq = UP_REQ; end
                 else nextReq = DONE;
      default:   nextReq = DONE;
    endcase

    if (nextReq == RIGHT_REQ && nRight == X_W'(X_RES - 1)) nextReq = LEFT_REQ;
    if (nextReq == LEFT_REQ && nLeft == '0) nextReq = DOWN_REQ;
    if (nextReq == DOWN_REQ && nBottom == Y_W'(Y_RES - 1)) nextReq = UP_REQ;
    if (nextReq == UP_REQ && nTop == '0) nextReq = DONE;

    sumX  = {1'b0, nLeft} + {1'b0, nRight};
    sumY  = {1'b0, nTop} + {1'b0, nBottom};
    nMidX = X_W'(sumX >> 1);
    nMidY = Y_W'(sumY >> 1);

    case (nextReq)
      RIGHT_REQ: nextAddr = addrOf(ySeed, nRight + X_W'(1));
      LEFT_REQ:  nextAddr = addrOf(ySeed, nLeft - X_W'(1));
      DOWN_REQ:  nextAddr = addrOf(nBottom + Y_W'(1), nMidX);
      UP_REQ:    nextAddr = addrOf(nTop - Y_W'(1), nMidX);
      default:   nextAddr = addrR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ySeed   <= '0;
      leftR   <= '0;
      rightR  <= '0;
      midXR   <= '0;
      topR    <= '0;
      bottomR <= '0;
      midYR   <= '0;
      errR    <= 1'b0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
      addrR   <= '0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ySeed   <= bus.y_in;
            leftR   <= bus.x_in;
            rightR  <= bus.x_in;
            midXR   <= bus.x_in;
            topR    <= bus.y_in;
            bottomR <= bus.y_in;
            midYR   <= bus.y_in;
            errR    <= 1'b0;
            busyR   <= 1'b1;
            addrR   <= addrOf(bus.y_in, bus.x_in);
            state   <= SEED_REQ;
          end
        end
        SEED_REQ:  state <= SEED_CHK;
        RIGHT_REQ: state <= RIGHT_CHK;
        LEFT_REQ:  state <= LEFT_CHK;
        DOWN_REQ:  state <= DOWN_CHK;
        UP_REQ:    state <= UP_CHK;
        SEED_CHK, RIGHT_CHK, LEFT_CHK, DOWN_CHK, UP_CHK: begin
          leftR   <= nLeft;
          rightR  <= nRight;
          topR    <= nTop;
          bottomR <= nBottom;
          if (seedDark) errR <= 1'b1;
          // mid_x is final once the row scans are over; it steers the column scans
          if (nextReq == DOWN_REQ || nextReq == UP_REQ || nextReq == DONE) midXR <= nMidX;
          if (nextReq == DONE) begin
            midYR <= nMidY;
            busyR <= 1'b0;
            doneR <= 1'b1;
          end
          addrR <= nextAddr;
          state <= nextReq;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr = addrR;
  assign bus.busy     = busyR;
  assign bus.done     = doneR;
  assign bus.err      = errR;
  assign bus.left     = leftR;
  assign bus.right    = rightR;
  assign bus.top      = topR;
  assign bus.bottom   = bottomR;
  assign bus.mid_x    = midXR;
  assign bus.mid_y    = midYR;

endmodule

// File: tb/tb_star_bbox_finder.sv
// Directed bench for star_bbox_finder: a frame-RAM model, a scan model of the star
// extents, and one negedge compare process, plus literal expectations per scenario.
module tb_star_bbox_finder;
  localparam int X_RES = 6, Y_RES = 6, X_W = 3, Y_W = 3, PIX_W = 3, ADDR_W = 6, THRESHOLD = 0;

  typedef struct {
    int left; int right; int top; int bottom; int midX; int midY; int err; int probes;
  } res_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  star_bbox_finder_if #(.X_W(X_W), .Y_W(Y_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus();

  star_bbox_finder #(
    .X_RES(X_RES), .Y_RES(Y_RES), .X_W(X_W), .Y_W(Y_W),
    .PIX_W(PIX_W), .ADDR_W(ADDR_W), .THRESHOLD(THRESHOLD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  logic [PIX_W-1:0] frame [0:63];
  always @(posedge clk) bus.mem_q <= frame[bus.mem_addr];

  int   vectors = 0, miscompares = 0;
  int   edgeCount = 0, startEdge = 0, doneEdge = 0;
  bit   opActive = 0, started = 0, doneFlag = 0, heldValid = 0;
  res_t pend, heldExp;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  always @(posedge clk)
    if (resetn && bus.start && !bus.busy)
      assert (bus.x_in < X_RES && bus.y_in < Y_RES) else $error("[TB] seed outside the frame");

  function automatic res_t zeroRes();
    res_t r;
    r.left = 0; r.right = 0; r.top = 0; r.bottom = 0;
    r.midX = 0; r.midY = 0; r.err = 0; r.probes = 0;
    return r;
  endfunction

  function automatic bit isBright(int x, int y);
    return int'(frame[y * X_RES + x]) > THRESHOLD;
  endfunction

  // Grow the box one pixel at a time in each direction, counting every RAM read.
  function automatic res_t model(int sx, int sy);
    res_t r;
    r = zeroRes();
    r.left = sx; r.right = sx; r.midX = sx;
    r.top = sy; r.bottom = sy; r.midY = sy;
    r.probes = 1;
    if (!isBright(sx, sy)) begin
      r.err = 1;
      return r;
    end
    while (r.right < X_RES - 1) begin
      r.probes++;
      if (isBright(r.right + 1, sy)) r.right++; else break;
    end
    while (r.left > 0) begin
      r.probes++;
      if (isBright(r.left - 1, sy)) r.left--; else break;
    end
    r.midX = (r.left + r.right) / 2;
    while (r.bottom < Y_RES - 1) begin
      r.probes++;
      if (isBright(r.midX, r.bottom + 1)) r.bottom++; else break;
    end
    while (r.top > 0) begin
      r.probes++;
      if (isBright(r.midX, r.top - 1)) r.top--; else break;
    end
    r.midY = (r.top + r.bottom) / 2;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Results at done, held results while idle, busy during a scan, address range.
  always @(negedge clk) begin
    if (!opActive) begin
      checkOutput("unexpectedDone", bus.done, 0);
      if (heldValid) begin
        checkOutput("idleBusy", bus.busy, 0);
        checkOutput("heldLeft", bus.left, heldExp.left);
        checkOutput("heldRight", bus.right, heldExp.right);
        checkOutput("heldTop", bus.top, heldExp.top);
        checkOutput("heldBottom", bus.bottom, heldExp.bottom);
        checkOutput("heldMidX", bus.mid_x, heldExp.midX);
        checkOutput("heldMidY", bus.mid_y, heldExp.midY);
        checkOutput("heldErr", bus.err, heldExp.err);
      end
    end else if (bus.done === 1'b1) begin
      checkOutput("left", bus.left, pend.left);
      checkOutput("right", bus.right, pend.right);
      checkOutput("top", bus.top, pend.top);
      checkOutput("bottom", bus.bottom, pend.bottom);
      checkOutput("midX", bus.mid_x, pend.midX);
      checkOutput("midY", bus.mid_y, pend.midY);
      checkOutput("err", bus.err, pend.err);
      checkOutput("busyAtDone", bus.busy, 0);
      checkOutput("latency", edgeCount - startEdge, 2 * pend.probes);
      heldExp  = pend;
      opActive = 0;
      started  = 0;
      doneFlag = 1;
      doneEdge = edgeCount;
    end else if (started) begin
      checkOutput("busyInFlight", bus.busy, 1);
    end
    if (bus.busy === 1'b1)
      checkOutput("addrRange", bus.mem_addr <= ADDR_W'(X_RES * Y_RES - 1), 1);
  end

  task automatic clearFrame();
    for (int i = 0; i < 64; i++) frame[i] = '0;
  endtask

  task automatic setBlock(input int x0, input int x1, input int y0, input int y1, input int val);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        frame[y * X_RES + x] = PIX_W'(val);
  endtask

  // Called between a rising edge and the next falling edge with the finder idle.
  task automatic applyStimulus(input int x, input int y, input bit holdStart);
    pend      = model(x, y);
    doneFlag  = 0;
    opActive  = 1;
    bus.start = 1'b1;
    bus.x_in  = x[X_W-1:0];
    bus.y_in  = y[Y_W-1:0];
    @(posedge clk);
    #1;
    startEdge = edgeCount;
    started   = 1;
    if (!holdStart) bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (doneFlag) break;
    end
    #1;
    if (!doneFlag) begin
      checkOutput("doneTimeout", doneFlag, 1);
      opActive = 0;
      started  = 0;
    end
  endtask

  task automatic checkResult(input string tag, input int l, input int r, input int t, input int b,
                             input int mx, input int my, input int e, input int lat);
    checkOutput({tag, " left"}, bus.left, l);
    checkOutput({tag, " right"}, bus.right, r);
    checkOutput({tag, " top"}, bus.top, t);
    checkOutput({tag, " bottom"}, bus.bottom, b);
    checkOutput({tag, " midX"}, bus.mid_x, mx);
    checkOutput({tag, " midY"}, bus.mid_y, my);
    checkOutput({tag, " err"}, bus.err, e);
    checkOutput({tag, " latency"}, doneEdge - startEdge, lat);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, bus.busy, 0);
    checkOutput({tag, " done"}, bus.done, 0);
    checkOutput({tag, " err"}, bus.err, 0);
    checkOutput({tag, " left"}, bus.left, 0);
    checkOutput({tag, " right"}, bus.right, 0);
    checkOutput({tag, " top"}, bus.top, 0);
    checkOutput({tag, " bottom"}, bus.bottom, 0);
    checkOutput({tag, " midX"}, bus.mid_x, 0);
    checkOutput({tag, " midY"}, bus.mid_y, 0);
    checkOutput({tag, " memAddr"}, bus.mem_addr, 0);
  endtask

  initial begin
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    clearFrame();
    heldExp   = zeroRes();
    heldValid = 1;
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] 3x3 block, seed (2,1)");
    setBlock(2, 4, 1, 3, 5);
    frame[5 * X_RES + 0] = 3'd7;
    applyStimulus(2, 1, 0);
    checkResult("block", 2, 4, 1, 3, 3, 2, 0, 18);

    $display("[TB] block against right and top edges, seed (3,0)");
    clearFrame();
    setBlock(3, 5, 0, 2, 3);
    applyStimulus(3, 0, 0);
    checkResult("edges", 3, 5, 0, 2, 4, 1, 0, 14);

    $display("[TB] dark seed then bright seed");
    clearFrame();
    applyStimulus(0, 0, 0);
    checkResult("darkSeed", 0, 0, 0, 0, 0, 0, 1, 2);
    frame[2 * X_RES + 3] = 3'd1;
    applyStimulus(3, 2, 0);
    checkResult("afterDark", 3, 3, 2, 2, 3, 2, 0, 10);

    $display("[TB] single pixel in the bottom-left corner");
    clearFrame();
    frame[5 * X_RES + 0] = 3'd2;
    applyStimulus(0, 5, 0);
    checkResult("corner", 0, 0, 5, 5, 0, 5, 0, 6);

    $display("[TB] reset during the downward scan");
    clearFrame();
    setBlock(2, 4, 1, 3, 5);
    pend      = model(2, 1);
    doneFlag  = 0;
    opActive  = 1;
    bus.start = 1'b1;
    bus.x_in  = 3'd2;
    bus.y_in  = 3'd1;
    @(posedge clk);
    #1;
    startEdge = edgeCount;
    started   = 1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    resetn   = 1'b0;
    opActive = 0;
    started  = 0;
    heldExp  = zeroRes();
    #1;
    checkAllZero("midReset");
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(2, 1, 0);
    checkResult("afterReset", 2, 4, 1, 3, 3, 2, 0, 18);

    $display("[TB] start held high across back-to-back operations");
    applyStimulus(2, 1, 1);
    checkResult("held1", 2, 4, 1, 3, 3, 2, 0, 18);
    applyStimulus(2, 1, 1);
    checkResult("held2", 2, 4, 1, 3, 3, 2, 0, 18);
    applyStimulus(2, 1, 0);
    checkResult("held3", 2, 4, 1, 3, 3, 2, 0, 18);

    $display("[TB] row reaching left edge, column scan stops at top edge");
    clearFrame();
    setBlock(0, 3, 2, 2, 4);
    frame[1 * X_RES + 1] = 3'd6;
    frame[0 * X_RES + 1] = 3'd1;
    applyStimulus(1, 2, 0);
    checkResult("rowCol", 0, 3, 0, 2, 1, 1, 0, 16);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
